// File: rtl/frame_assembler_pkg.sv
// rtl/frame_assembler_pkg.sv - shared state encodings and index-width helper for streaming stages
package frame_assembler_pkg;

  // Frame buffer state: collecting pixels, or holding a complete frame
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } fa_state_t;

  // Width of a raster index covering n slots; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_assembler_raster_counter.sv
// rtl/frame_assembler_raster_counter.sv - raster index with increment, wrap and resync load
module raster_counter
  import frame_assembler_pkg::*;
#(
  parameter int N = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_inc,
  input  logic                    i_load1,
  output logic [idx_width(N)-1:0] o_idx,
  output logic                    o_tc
);

  localparam int W = idx_width(N);

  logic [W-1:0] r_idx;

  // Resync load takes priority over a normal advance; wrap at the last slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (i_load1) begin
      r_idx <= (N > 1) ? W'(1) : '0;
    end else if (i_inc) begin
      r_idx <= o_tc ? '0 : r_idx + W'(1);
    end
  end

  // Terminal count marks the final slot of the frame
  always_comb begin
    o_idx = r_idx;
    o_tc  = (r_idx == W'(N - 1));
  end

endmodule

// File: rtl/frame_assembler.sv
// rtl/frame_assembler.sv - collects a raster pixel stream into one packed frame
module frame_assembler
  import frame_assembler_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AX    = 8,
  parameter int AY    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DEPTH-1:0]      pix_in,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  output logic                  pix_ready,
  output logic [DEPTH*AX*AY-1:0] frame_out,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  sync_err
);

  localparam int N = AX * AY;
  localparam int W = idx_width(N);

  fa_state_t            r_state;
  fa_state_t            w_state_nxt;
  logic [DEPTH*N-1:0]   r_frame;
  logic                 r_sync_err;
  logic [W-1:0]         w_idx;
  logic                 w_tc;
  logic                 w_accept;
  logic                 w_resync;
  logic                 w_inc;
  logic [W-1:0]         w_slot;

  // A start-of-frame seen mid-frame restarts the fill with this pixel in slot 0
  always_comb begin
    w_accept = pix_valid && (r_state == ST_FILL);
    w_resync = w_accept && pix_sof && (w_idx != '0);
    w_inc    = w_accept && !w_resync;
    w_slot   = w_resync ? '0 : w_idx;
  end

  raster_counter #(
    .N(N)
  ) u_raster_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_inc),
    .i_load1(w_resync),
    .o_idx  (w_idx),
    .o_tc   (w_tc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: fill until the last slot lands, hold until the consumer takes it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: if (w_inc && w_tc) w_state_nxt = ST_FULL;
      ST_FULL: if (frame_ready)   w_state_nxt = ST_FILL;
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // Outputs decoded from the state register only, so handshake inputs never reach them
  always_comb begin
    pix_ready   = (r_state == ST_FILL);
    frame_valid = (r_state == ST_FULL);
    frame_out   = r_frame;
    sync_err    = r_sync_err;
  end

  // Frame storage: each accepted pixel overwrites its raster slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
    end else if (w_accept) begin
      r_frame[int'(w_slot)*DEPTH +: DEPTH] <= pix_in;
    end
  end

  // Resync indication lasts exactly the cycle after the offending pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= w_resync;
    end
  end

endmodule

// File: tb/tb_frame_assembler.sv
// tb/tb_frame_assembler.sv - directed self-checking bench for frame_assembler
module tb_frame_assembler;

  logic         clk;
  logic         rst_n;
  logic [7:0]   pix_in;
  logic         pix_valid;
  logic         pix_sof;
  logic         pix_ready;
  logic [511:0] frame_out;
  logic         frame_valid;
  logic         frame_ready;
  logic         sync_err;

  int n_checks;
  int n_fail;
  logic [511:0] exp_frame;
  int sync_cnt;

  frame_assembler #(.DEPTH(8), .AX(8), .AY(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .frame_out  (frame_out),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input logic s);
    pix_in    = v;
    pix_sof   = s;
    pix_valid = 1'b1;
    tick();
    if (sync_err) sync_cnt++;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic consume();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    sync_cnt    = 0;
    rst_n       = 1'b0;
    pix_in      = '0;
    pix_valid   = 1'b0;
    pix_sof     = 1'b0;
    frame_ready = 1'b0;
    #1;
    chk("rst_pix_ready", 512'(pix_ready), 512'd1);
    chk("rst_frame_valid", 512'(frame_valid), 512'd0);
    chk("rst_sync_err", 512'(sync_err), 512'd0);
    chk("rst_frame_out", frame_out, 512'd0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 512'(pix_ready), 512'd1);

    // back-to-back raster fill, value = slot index
    for (int k = 0; k < 64; k++) begin
      pix_in = 8'(k); pix_sof = (k == 0); pix_valid = 1'b1;
      tick();
      if (k == 62) chk("fv_before_last", 512'(frame_valid), 512'd0);
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
    for (int k = 0; k < 64; k++) exp_frame[k*8 +: 8] = 8'(k);
    chk("fill_frame_valid", 512'(frame_valid), 512'd1);
    chk("fill_pix_ready", 512'(pix_ready), 512'd0);
    chk("fill_frame", frame_out, exp_frame);
    chk("fill_slot0", 512'(frame_out[7:0]), 512'h00);
    chk("fill_slot63", 512'(frame_out[511:504]), 512'h3F);

    // backpressure: pixels offered while full must be refused
    pix_in = 8'h55; pix_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_pix_ready", 512'(pix_ready), 512'd0);
      chk("hold_frame", frame_out, exp_frame);
    end
    chk("hold_frame_valid", 512'(frame_valid), 512'd1);
    consume();
    pix_valid = 1'b0;
    chk("consumed_fv", 512'(frame_valid), 512'd0);
    chk("consumed_ready", 512'(pix_ready), 512'd1);
    chk("consumed_frame", frame_out, exp_frame);

    // resync: 20 pixels, then a mid-frame start-of-frame
    sync_cnt = 0;
    for (int k = 0; k < 20; k++) send(8'(8'h80 + k), (k == 0));
    chk("sof_at_zero_no_err", 512'(sync_cnt), 512'd0);
    send(8'hAA, 1'b1);
    chk("resync_pulse", 512'(sync_err), 512'd1);
    chk("resync_slot0", 512'(frame_out[7:0]), 512'hAA);
    tick();
    chk("resync_pulse_end", 512'(sync_err), 512'd0);
    for (int k = 1; k < 64; k++) begin
      send(8'(k), 1'b0);
      if (k == 62) chk("resync_fv_early", 512'(frame_valid), 512'd0);
    end
    exp_frame[7:0] = 8'hAA;
    for (int k = 1; k < 64; k++) exp_frame[k*8 +: 8] = 8'(k);
    chk("resync_fv", 512'(frame_valid), 512'd1);
    chk("resync_frame", frame_out, exp_frame);
    chk("resync_pulse_count", 512'(sync_cnt), 512'd1);
    consume();

    // valid toggling; SOF on idle cycles must be ignored
    sync_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      send(8'(63 - k), 1'b0);
      if (k == 63) chk("toggle_fv", 512'(frame_valid), 512'd1);
      else         chk("toggle_fv_low", 512'(frame_valid), 512'd0);
      pix_in = 8'hEE; pix_sof = 1'b1; pix_valid = 1'b0;
      tick();
      if (sync_err) sync_cnt++;
      pix_sof = 1'b0;
    end
    for (int k = 0; k < 64; k++) exp_frame[k*8 +: 8] = 8'(63 - k);
    chk("toggle_frame", frame_out, exp_frame);
    chk("toggle_no_err", 512'(sync_cnt), 512'd0);
    consume();

    // asynchronous reset mid-frame
    for (int k = 0; k < 30; k++) send(8'(k + 100), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pix_ready", 512'(pix_ready), 512'd1);
    chk("arst_frame_valid", 512'(frame_valid), 512'd0);
    chk("arst_sync_err", 512'(sync_err), 512'd0);
    chk("arst_frame_out", frame_out, 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_release_ready", 512'(pix_ready), 512'd1);
    for (int k = 0; k < 64; k++) send(8'(k) ^ 8'h5A, 1'b0);
    for (int k = 0; k < 64; k++) exp_frame[k*8 +: 8] = 8'(k) ^ 8'h5A;
    chk("arst_fv", 512'(frame_valid), 512'd1);
    chk("arst_frame", frame_out, exp_frame);
    consume();

    // two frames with consumer always ready
    frame_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      pix_in = 8'(k + 1); pix_valid = 1'b1; tick();
    end
    for (int k = 0; k < 64; k++) exp_frame[k*8 +: 8] = 8'(k + 1);
    chk("ff_a_fv", 512'(frame_valid), 512'd1);
    chk("ff_a_frame", frame_out, exp_frame);
    pix_in = 8'd0;
    tick();
    chk("ff_a_fv_one_cycle", 512'(frame_valid), 512'd0);
    chk("ff_idle_ready", 512'(pix_ready), 512'd1);
    for (int k = 0; k < 64; k++) begin
      pix_in = 8'(2 * k); pix_valid = 1'b1; tick();
    end
    pix_valid = 1'b0;
    for (int k = 0; k < 64; k++) exp_frame[k*8 +: 8] = 8'(2 * k);
    chk("ff_b_fv", 512'(frame_valid), 512'd1);
    chk("ff_b_frame", frame_out, exp_frame);
    tick();
    chk("ff_b_fv_one_cycle", 512'(frame_valid), 512'd0);
    frame_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_assembler.md
FRAME_ASSEMBLER -- requirements
Module: frame_assembler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving the bit width of one pixel.
REQ-002 SHALL have parameter AX, default 8, giving the frame width in pixels (x, fastest-varying).
REQ-003 SHALL have parameter AY, default 8, giving the frame height in pixels (y).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port pix_in, input, DEPTH bits: the incoming pixel.
REQ-007 SHALL have port pix_valid, input, 1 bit: pix_in (and pix_sof) valid this cycle.
REQ-008 SHALL have port pix_sof, input, 1 bit: the current pixel is the first pixel of a frame.
REQ-009 SHALL have port pix_ready, output, 1 bit: the block accepts a pixel this cycle.
REQ-010 SHALL have port frame_out, output, DEPTH*AX*AY bits: the packed frame, feeding the pooling stage input bus.
REQ-011 SHALL have port frame_valid, output, 1 bit: frame_out holds a complete frame.
REQ-012 SHALL have port frame_ready, input, 1 bit: the downstream stage consumes the frame.
REQ-013 SHALL have port sync_err, output, 1 bit: one-cycle pulse on a frame resynchronisation.

Function
REQ-014 SHALL implement a two-state FSM: FILL (pix_ready=1, frame_valid=0) and FULL (pix_ready=0, frame_valid=1).
REQ-015 SHALL treat a pixel as accepted only when pix_valid=1 and pix_ready=1 on the same clock edge.
REQ-016 SHALL keep a raster index idx in 0..AX*AY-1, width $clog2(AX*AY), with x=idx mod AX and y=idx div AX.
REQ-017 SHALL write each accepted pixel to frame_out[(y*AX+x)*DEPTH +: DEPTH], i.e. slot idx.
REQ-018 SHALL increment idx by 1 per accepted pixel; on acceptance at idx=AX*AY-1 it SHALL wrap idx to 0 and enter FULL.
REQ-019 SHALL assert frame_valid in the cycle immediately after the last pixel's handshake (latency 1 cycle).
REQ-020 SHALL hold frame_out and frame_valid stable while in FULL and frame_ready=0.
REQ-021 SHALL return from FULL to FILL on the edge where frame_valid=1 and frame_ready=1, with pix_ready=1 in the next cycle.
REQ-022 SHALL NOT accept a pixel in the cycle the frame is consumed: no bypass, because pix_ready=0 throughout FULL.
REQ-023 SHALL, when a pixel with pix_sof=1 is accepted at idx=0, treat it as normal and leave sync_err=0.
REQ-024 SHALL, when a pixel with pix_sof=1 is accepted at idx≠0, write it to slot 0, set idx=1, discard the partial frame, and pulse sync_err=1 for one cycle.
REQ-025 SHALL ignore pix_sof unless the pixel is accepted.
REQ-026 SHALL leave slots not yet overwritten in the current fill at their previous values; frame_out is meaningful only while frame_valid=1.
REQ-027 SHALL, for AX*AY=1, enter FULL after every accepted pixel.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state=FILL, idx=0, frame_out=0, frame_valid=0, sync_err=0, and pix_ready=1.
REQ-029 SHALL discard any partial or held frame when reset is asserted mid-operation; after release the next accepted pixel goes to slot 0.
REQ-030 SHALL drive pix_ready=1 in the first cycle after rst_n deasserts.

Structure
REQ-031 SHALL place the state encodings (FILL, FULL) and the index-width function in a shared include/package used by this block and by later streaming stages.
REQ-032 SHALL contain one sub-module, raster_counter, holding idx with increment, wrap and load-1 (resync) controls and a terminal-count output.
REQ-033 SHALL register all outputs: no combinational path from pix_valid or frame_ready to any output.

Verification
REQ-034 SHALL cover: after reset, stream 64 pixels of value idx (0..63) back-to-back -> frame_valid rises 1 cycle after pixel 63; slot k=k; frame_out[7:0]=0x00 and frame_out[511:504]=0x3F.
REQ-035 SHALL cover: hold frame_ready=0 for 10 cycles with pix_valid=1 -> pix_ready=0, frame_out unchanged, no pixel accepted; then frame_ready=1 for one cycle -> FILL next cycle.
REQ-036 SHALL cover: after 20 pixels, send pix_sof=1 with value 0xAA -> sync_err pulses once, slot 0=0xAA, and the frame completes after 63 further pixels.
REQ-037 SHALL cover: pix_valid toggling 1/0 every cycle -> exactly 64 accepts, frame_valid 1 cycle after the 64th, pixel order preserved.
REQ-038 SHALL cover: assert rst_n=0 after 30 pixels -> all outputs at reset values asynchronously; a fresh 64-pixel frame assembles correctly.
REQ-039 SHALL cover: two consecutive frames with frame_ready tied to 1 -> each frame_valid lasts exactly 1 cycle and one idle cycle occurs between frames.
